// File: rtl/adder_operand_sequencer.sv
// Debounces key_n into a one-cycle press and steps x -> y/carry_in capture (define ADDER_OPERAND_SEQUENCER_DEBOUNCE_BYPASS_EN to skip debouncing).
// Latency: press is high DEBOUNCE_CYCLES+3 edges after key_n falls (4 edges in bypass); the FSM acts on the following edge.
// Backpressure: x/y/carry_in are held with out_valid until out_valid & out_ready; a new press drops an unaccepted pair.
module adder_operand_sequencer #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             key_n,
   input  logic [WIDTH-1:0] sw_data,
   input  logic             sw_cin,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       phase,
   output logic             press
);

   typedef enum logic [1:0] {
      ENTER_X = 2'd0,
      ENTER_Y = 2'd1,
      PRESENT = 2'd2
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   logic             w_s;
   logic             r_db;
   logic             r_db_prev;
   logic             r_press;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] w_x_nxt;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] w_y_nxt;
   logic             r_cin;
   logic             w_cin_nxt;
   logic             r_valid;
   logic             w_valid_nxt;

   // Synchronisers idle at the released level so reset never fakes a press.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= key_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;

`ifdef ADDER_OPERAND_SEQUENCER_DEBOUNCE_BYPASS_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_db <= 1'b1;
      end else begin
         r_db <= w_s;
      end
   end
`else
   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   // The level must differ from db for DEBOUNCE_CYCLES consecutive edges to be accepted.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_db  <= 1'b1;
         r_cnt <= '0;
      end else if (w_s == r_db) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_db  <= w_s;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_db_prev <= 1'b1;
         r_press   <= 1'b0;
      end else begin
         r_db_prev <= r_db;
         r_press   <= r_db_prev & ~r_db;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= ENTER_X;
         r_x     <= '0;
         r_y     <= '0;
         r_cin   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_cin   <= w_cin_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_cin_nxt   = r_cin;
      w_valid_nxt = r_valid;
      case (r_state)
         ENTER_X: begin
            if (r_press) begin
               w_x_nxt     = sw_data;
               w_state_nxt = ENTER_Y;
            end
         end
         ENTER_Y: begin
            if (r_press) begin
               w_y_nxt     = sw_data;
               w_cin_nxt   = sw_cin;
               w_valid_nxt = 1'b1;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            // A press outranks a same-edge handshake: the pair is dropped, not delivered.
            if (r_press) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ENTER_X;
            end else if (r_valid && out_ready) begin
               w_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ENTER_X;
         end
      endcase
   end

   assign x         = r_x;
   assign y         = r_y;
   assign carry_in  = r_cin;
   assign out_valid = r_valid;
   assign phase     = r_state;
   assign press     = r_press;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: directed entry/handshake/glitch/reset steps plus random key and switch activity against a queue-based model.
module tb_adder_operand_sequencer;

   localparam int W = 4;
   localparam int D = 4;
`ifdef ADDER_OPERAND_SEQUENCER_DEBOUNCE_BYPASS_EN
   localparam int DW = 1;
`else
   localparam int DW = D;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         key_n = 1'b1;
   logic [W-1:0] sw_data = '0;
   logic         sw_cin = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         carry_in;
   logic         out_valid;
   logic [1:0]   phase;
   logic         press;

   int checks = 0;
   int errors = 0;

   // Reference model: key samples two edges back form the synchronised level;
   // the debounced level flips once the last DW samples all disagree with it.
   bit           kq[$];
   bit           sq[$];
   bit           m_db = 1'b1;
   bit           m_fell = 1'b0;
   bit           m_press = 1'b0;
   int           m_phase = 0;
   logic [W-1:0] m_x = '0;
   logic [W-1:0] m_y = '0;
   bit           m_cin = 1'b0;
   bit           m_valid = 1'b0;
   int           edge_no = 0;
   int           press_cnt = 0;
   int           first_press = -1;

   adder_operand_sequencer #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clock(clock),
      .reset(reset),
      .key_n(key_n),
      .sw_data(sw_data),
      .sw_cin(sw_cin),
      .x(x),
      .y(y),
      .carry_in(carry_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .phase(phase),
      .press(press)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit s;
      bit fell;
      bit all_diff;
      bit p_old;
      edge_no++;
      if (!reset) begin
         kq = '{1'b1, 1'b1};
         sq.delete();
         m_db = 1'b1; m_fell = 1'b0; m_press = 1'b0;
         m_phase = 0; m_x = '0; m_y = '0; m_cin = 1'b0; m_valid = 1'b0;
         return;
      end
      p_old = m_press;
      s = kq[0];
      void'(kq.pop_front());
      kq.push_back(key_n);
      sq.push_back(s);
      if (sq.size() > DW) void'(sq.pop_front());
      fell = 1'b0;
      if (sq.size() == DW) begin
         all_diff = 1'b1;
         foreach (sq[i]) if (sq[i] == m_db) all_diff = 1'b0;
         if (all_diff) begin
            fell = m_db;
            m_db = ~m_db;
            sq.delete();
         end
      end
      m_press = m_fell;
      m_fell = fell;
      case (m_phase)
         0: if (p_old) begin m_x = sw_data; m_phase = 1; end
         1: if (p_old) begin m_y = sw_data; m_cin = sw_cin; m_valid = 1'b1; m_phase = 2; end
         default: begin
            if (p_old) begin m_phase = 0; m_valid = 1'b0; end
            else if (m_valid && out_ready) m_valid = 1'b0;
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      if (press === 1'b1) begin
         press_cnt++;
         if (first_press < 0) first_press = edge_no;
      end
      chk("x", 32'(x), 32'(m_x));
      chk("y", 32'(y), 32'(m_y));
      chk("carry_in", 32'(carry_in), 32'(m_cin));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("phase", 32'(phase), 32'(m_phase));
      chk("press", 32'(press), 32'(m_press));
   endtask

   task automatic push_key(input int low);
      key_n = 1'b0;
      repeat (low) tick();
      key_n = 1'b1;
      repeat (DW + 8) tick();
   endtask

   initial begin
      int e0;
      kq = '{1'b1, 1'b1};

      // Reset state
      reset = 1'b0;
      repeat (2) tick();
      chk("rst_x", 32'(x), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_phase", 32'(phase), 32'h0);
      chk("rst_press", 32'(press), 32'h0);
      reset = 1'b1;
      repeat (3) tick();

      // Entry sequence
      sw_data = 4'hA;
      push_key(10);
      chk("entry_x", 32'(x), 32'hA);
      chk("entry_phase1", 32'(phase), 32'h1);
      chk("entry_valid0", 32'(out_valid), 32'h0);
      sw_data = 4'h7; sw_cin = 1'b1;
      push_key(10);
      chk("entry_y", 32'(y), 32'h7);
      chk("entry_cin", 32'(carry_in), 32'h1);
      chk("entry_valid1", 32'(out_valid), 32'h1);
      chk("entry_phase2", 32'(phase), 32'h2);

      // Handshake hold, then accept
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sw_data = W'($urandom); sw_cin = 1'($urandom);
         tick();
      end
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_x", 32'(x), 32'hA);
      chk("hold_y", 32'(y), 32'h7);
      chk("hold_cin", 32'(carry_in), 32'h1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("accept_valid", 32'(out_valid), 32'h0);
      chk("accept_x", 32'(x), 32'hA);
      chk("accept_y", 32'(y), 32'h7);
      chk("accept_phase", 32'(phase), 32'h2);

      // Glitch of 3 clocks
      press_cnt = 0;
      key_n = 1'b0;
      repeat (3) tick();
      key_n = 1'b1;
      repeat (15) tick();
      chk("glitch3_presses", 32'(press_cnt), (3 >= DW) ? 32'd1 : 32'd0);

      // One-cycle pulse
      press_cnt = 0; first_press = -1; e0 = edge_no;
      key_n = 1'b0;
      tick();
      key_n = 1'b1;
      repeat (15) tick();
      chk("pulse1_presses", 32'(press_cnt), (DW == 1) ? 32'd1 : 32'd0);
      chk("pulse1_latency", 32'((first_press < 0) ? -1 : first_press - e0), (DW == 1) ? 32'd4 : 32'hFFFF_FFFF);

      // Ten-clock press: exactly one pulse at the stated latency
      repeat (DW + 4) tick();
      press_cnt = 0; first_press = -1; e0 = edge_no;
      key_n = 1'b0;
      repeat (10) tick();
      key_n = 1'b1;
      repeat (DW + 8) tick();
      chk("low10_presses", 32'(press_cnt), 32'd1);
      chk("low10_latency", 32'(first_press - e0), 32'(DW + 3));

      // Re-enter, then press and out_ready on the same edge
      sw_data = 4'h5; push_key(10);
      sw_data = 4'h9; sw_cin = 1'b0; push_key(10);
      chk("drop_pre_valid", 32'(out_valid), 32'h1);
      key_n = 1'b0;
      repeat (DW + 3) tick();
      chk("drop_press_hi", 32'(press), 32'h1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("drop_phase", 32'(phase), 32'h0);
      chk("drop_valid", 32'(out_valid), 32'h0);
      chk("drop_y", 32'(y), 32'h9);
      key_n = 1'b1;
      repeat (DW + 8) tick();

      // Reset while in ENTER_Y, key held through release
      sw_data = 4'h3; push_key(10);
      chk("mid_x", 32'(x), 32'h3);
      key_n = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mrst_x", 32'(x), 32'h0);
      chk("mrst_y", 32'(y), 32'h0);
      chk("mrst_phase", 32'(phase), 32'h0);
      chk("mrst_valid", 32'(out_valid), 32'h0);
      press_cnt = 0; first_press = -1; e0 = edge_no;
      repeat (DW + 6) tick();
      chk("mrst_latency", 32'(first_press - e0), 32'(DW + 3));
      key_n = 1'b1;
      repeat (DW + 8) tick();

      // Random key activity, switches, out_ready and occasional reset
      for (int i = 0; i < 120; i++) begin
         int lo;
         int hi;
         lo = int'($urandom_range(1, 12));
         hi = int'($urandom_range(1, 12));
         key_n = 1'b0;
         for (int j = 0; j < lo; j++) begin
            sw_data = W'($urandom); sw_cin = 1'($urandom);
            out_ready = 1'($urandom);
            reset = ($urandom_range(0, 63) != 0);
            tick();
         end
         key_n = 1'b1;
         for (int j = 0; j < hi; j++) begin
            sw_data = W'($urandom); sw_cin = 1'($urandom);
            out_ready = 1'($urandom);
            reset = ($urandom_range(0, 63) != 0);
            tick();
         end
      end
      reset = 1'b1;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
